nvdla_sdp_mcif_rd_responder: RTL and testbench

- Memory-side responder for the SDP DMA read channel (the sdp2mcif_rd_req / mcif2sdp_rd_rsp / sdp2mcif_rd_cdt_lat_fifo_pop triple).
- Accepts read requests from SDP and issues one-atom reads to a fixed-latency SRAM-style backing port.
- Returns 256b response beats to SDP, honouring both valid/ready backpressure and the client's latency-FIFO credit scheme.
- Used as the MCIF/CVIF stand-in in partition-level benches and in FPGA builds without a full MCIF.

---
 rtl/nvdla_dma_pkg.sv | 26 ++
 rtl/nvdla_sdp_mcif_rd_responder_if.sv | 23 ++
 rtl/nvdla_sdp_rd_rsp_fifo2.sv | 38 +++
 rtl/nvdla_sdp_mcif_rd_responder.sv | 119 +++++++++++
 tb/tb_nvdla_sdp_mcif_rd_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nvdla_dma_pkg.sv
// Shared widths, field offsets and FSM state encoding for the SDP DMA read channel.
package nvdla_dma_pkg;

  localparam int DMA_RD_REQ_W = 79;
  localparam int DMA_RD_RSP_W = 257;
  localparam int DMA_ADDR_W   = 64;
  localparam int DMA_SIZE_W   = 15;
  localparam int DMA_DATA_W   = 256;
  localparam int ATOM_SHIFT   = 5;
  localparam int MEM_ADDR_W   = DMA_ADDR_W - ATOM_SHIFT;

  localparam int REQ_ADDR_LSB = 0;
  localparam int REQ_ADDR_MSB = 63;
  localparam int REQ_SIZE_LSB = 64;
  localparam int REQ_SIZE_MSB = 78;

  localparam int RSP_DATA_LSB = 0;
  localparam int RSP_DATA_MSB = 255;
  localparam int RSP_MASK_BIT = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/nvdla_sdp_mcif_rd_responder_if.sv
// SDP-side read channel bundle: request, response beat and latency-FIFO credit return.
interface nvdla_sdp_mcif_rd_responder_if;
  import nvdla_dma_pkg::*;

  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [DMA_RD_REQ_W-1:0] rd_req_pd;
  logic                    rd_rsp_valid;
  logic                    rd_rsp_ready;
  logic [DMA_RD_RSP_W-1:0] rd_rsp_pd;
  logic                    rd_cdt_lat_fifo_pop;

  modport master (
    output rd_req_valid, rd_req_pd, rd_rsp_ready, rd_cdt_lat_fifo_pop,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_pd
  );

  modport slave (
    input  rd_req_valid, rd_req_pd, rd_rsp_ready, rd_cdt_lat_fifo_pop,
    output rd_req_ready, rd_rsp_valid, rd_rsp_pd
  );

endinterface

// File: rtl/nvdla_sdp_rd_rsp_fifo2.sv
// Two-entry response data FIFO; head visible combinationally, push and pop in the same cycle at any occupancy.
// No full/empty protection: the caller guarantees it never pushes into a full FIFO without popping.
module nvdla_sdp_rd_rsp_fifo2
  import nvdla_dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DMA_DATA_W-1:0] push_data,
  input  logic                  pop,
  output logic [DMA_DATA_W-1:0] head_data,
  output logic [1:0]            count
);

  logic [DMA_DATA_W-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/nvdla_sdp_mcif_rd_responder.sv
// Memory-side responder for the SDP DMA read channel: one atom read per cycle into a 2-deep beat FIFO.
// Best case request->first beat is 3 cycles; issue stalls on zero credits or when 2 beats are queued/in flight.
module nvdla_sdp_mcif_rd_responder
  import nvdla_dma_pkg::*;
#(
  parameter int LAT_DEPTH = 16,
  parameter int CNT_W     = 8
)
(
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  nvdla_sdp_mcif_rd_responder_if.slave sdp,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [DMA_DATA_W-1:0] mem_rd_data,
  output logic [CNT_W-1:0]      credit_cnt,
  output logic                  err_credit_ovf
);

  rd_state_e             state;
  logic                  req_ready;
  logic [MEM_ADDR_W-1:0] cur_addr;
  logic [DMA_SIZE_W-1:0] remaining;
  logic                  inflight;
  logic [1:0]            fifo_count;
  logic [DMA_DATA_W-1:0] head_data;
  logic                  issue;
  logic                  rsp_valid;
  logic                  rsp_pop;
  logic                  cdt_pop;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^sdp.rd_req_pd[ATOM_SHIFT-1:0];

  // In-flight read counts against FIFO space so the capture never lands in a full FIFO.
  assign issue = !nvdla_core_rst && (state == ST_BURST) && (credit_cnt != '0) &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sdp.rd_req_valid && req_ready) begin
            cur_addr  <= sdp.rd_req_pd[REQ_ADDR_MSB:ATOM_SHIFT];
            remaining <= sdp.rd_req_pd[REQ_SIZE_MSB:REQ_SIZE_LSB];
            req_ready <= 1'b0;
            state     <= ST_BURST;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_BURST: begin
          if (issue) begin
            cur_addr  <= cur_addr + MEM_ADDR_W'(1);
            remaining <= remaining - DMA_SIZE_W'(1);
            if (remaining == '0) begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
    end
  end

  assign cdt_pop = sdp.rd_cdt_lat_fifo_pop;

  // Credit is reserved at issue; a surplus return is clamped and flagged.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      credit_cnt     <= CNT_W'(LAT_DEPTH);
      err_credit_ovf <= 1'b0;
    end else if (issue && !cdt_pop) begin
      credit_cnt <= credit_cnt - CNT_W'(1);
    end else if (cdt_pop && !issue) begin
      if (credit_cnt == CNT_W'(LAT_DEPTH)) begin
        err_credit_ovf <= 1'b1;
      end else begin
        credit_cnt <= credit_cnt + CNT_W'(1);
      end
    end
  end

  nvdla_sdp_rd_rsp_fifo2 u_rsp_fifo (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .push      (inflight),
    .push_data (mem_rd_data),
    .pop       (rsp_pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign rsp_valid        = (fifo_count != 2'd0);
  assign rsp_pop          = rsp_valid && sdp.rd_rsp_ready;
  assign sdp.rd_rsp_valid = rsp_valid;
  assign sdp.rd_rsp_pd    = rsp_valid ? {1'b1, head_data} : '0;
  assign sdp.rd_req_ready = req_ready;
  assign mem_rd_en        = issue;
  assign mem_rd_addr      = cur_addr;

endmodule

// File: tb/tb_nvdla_sdp_mcif_rd_responder.sv
// Scoreboarded bench: instance a (LAT_DEPTH=16) carries data/order checks, instance b (LAT_DEPTH=2) credit stalls.
`timescale 1ns/1ps
module tb_nvdla_sdp_mcif_rd_responder;
  import nvdla_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nvdla_sdp_mcif_rd_responder_if a_if ();
  nvdla_sdp_mcif_rd_responder_if b_if ();

  logic        a_mem_en, b_mem_en;
  logic [58:0] a_mem_addr, b_mem_addr;
  logic [255:0] a_mem_data, b_mem_data;
  logic [7:0]  a_cnt, b_cnt;
  logic        a_err, b_err;

  nvdla_sdp_mcif_rd_responder #(.LAT_DEPTH(16), .CNT_W(8)) dut_a (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .sdp            (a_if),
    .mem_rd_en      (a_mem_en),
    .mem_rd_addr    (a_mem_addr),
    .mem_rd_data    (a_mem_data),
    .credit_cnt     (a_cnt),
    .err_credit_ovf (a_err)
  );

  nvdla_sdp_mcif_rd_responder #(.LAT_DEPTH(2), .CNT_W(8)) dut_b (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .sdp            (b_if),
    .mem_rd_en      (b_mem_en),
    .mem_rd_addr    (b_mem_addr),
    .mem_rd_data    (b_mem_data),
    .credit_cnt     (b_cnt),
    .err_credit_ovf (b_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [256:0] act, logic [256:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void fail_unexpected(string name, logic [256:0] act);
    n_chk++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endfunction

  function automatic logic [255:0] pat(logic [58:0] a);
    logic [63:0] w;
    if (a == 59'h80) return {32{8'hA5}};
    w = {5'd0, a} ^ 64'hC3C3_0000_0000_0000;
    return {4{w}};
  endfunction

  // Backing memory models: data one cycle after the read strobe.
  always @(posedge clk) begin
    a_mem_data <= a_mem_en ? pat(a_mem_addr) : {8{32'hDEADBEEF}};
    b_mem_data <= {8{32'h1234_5678}};
  end

  logic [256:0] exp_pd[$];
  logic [58:0]  exp_addr[$];
  int           issued = 0;
  int           beats = 0;
  int           b_issued = 0;
  logic         stall_prev = 1'b0;
  logic [256:0] pd_prev = '0;

  always @(negedge clk) begin
    if (rst) begin
      issued     = 0;
      beats      = 0;
      b_issued   = 0;
      stall_prev = 1'b0;
    end else begin
      if (b_mem_en) b_issued++;
      if (a_mem_en) begin
        check("outstanding_le2", 257'((issued - beats) < 2), 257'd1);
        issued++;
        if (exp_addr.size() == 0) fail_unexpected("unexpected_issue", 257'(a_mem_addr));
        else check("issue_addr", 257'(a_mem_addr), 257'(exp_addr.pop_front()));
      end
      if (stall_prev && a_if.rd_rsp_valid)
        check("pd_stable", a_if.rd_rsp_pd, pd_prev);
      if (a_if.rd_rsp_valid && a_if.rd_rsp_ready) begin
        beats++;
        if (exp_pd.size() == 0) fail_unexpected("unexpected_beat", a_if.rd_rsp_pd);
        else check("beat_pd", a_if.rd_rsp_pd, exp_pd.pop_front());
      end
      stall_prev = a_if.rd_rsp_valid && !a_if.rd_rsp_ready;
      pd_prev    = a_if.rd_rsp_pd;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit use_b, input logic [63:0] addr, input logic [14:0] size);
    bit done = 1'b0;
    logic [58:0] atom;
    if (use_b) begin b_if.rd_req_valid = 1'b1; b_if.rd_req_pd = {size, addr}; end
    else       begin a_if.rd_req_valid = 1'b1; a_if.rd_req_pd = {size, addr}; end
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = use_b ? b_if.rd_req_ready : a_if.rd_req_ready;
      @(posedge clk);
      #1;
    end
    a_if.rd_req_valid = 1'b0;
    b_if.rd_req_valid = 1'b0;
    if (!done) fail_unexpected("req_accept_timeout", 257'(addr));
    else if (!use_b) begin
      atom = addr[63:5];
      for (int i = 0; i <= int'(size); i++) begin
        exp_addr.push_back(atom);
        exp_pd.push_back({1'b1, pat(atom)});
        atom = atom + 59'd1;
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (exp_pd.size() != 0 || exp_addr.size() != 0); t++) tick();
    check("drain_pd", 257'(exp_pd.size()), 257'd0);
  endtask

  task automatic pop_a(int n);
    a_if.rd_cdt_lat_fifo_pop = 1'b1;
    tick(n);
    a_if.rd_cdt_lat_fifo_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b0;
    bit hit;
    a_if.rd_req_valid = 0; a_if.rd_req_pd = '0; a_if.rd_rsp_ready = 0; a_if.rd_cdt_lat_fifo_pop = 0;
    b_if.rd_req_valid = 0; b_if.rd_req_pd = '0; b_if.rd_rsp_ready = 0; b_if.rd_cdt_lat_fifo_pop = 0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 257'(a_if.rd_req_ready), 257'd0);
    check("rst_rsp_valid", 257'(a_if.rd_rsp_valid), 257'd0);
    check("rst_rsp_pd", a_if.rd_rsp_pd, 257'd0);
    check("rst_mem_en", 257'(a_mem_en), 257'd0);
    check("rst_mem_addr", 257'(a_mem_addr), 257'd0);
    check("rst_credit", 257'(a_cnt), 257'd16);
    check("rst_err", 257'(a_err), 257'd0);
    tick();

    // Single atom: latency and credit round trip
    send(1'b0, 64'h1000, 15'd0);
    @(negedge clk);
    check("t1_en_T1", 257'(a_mem_en), 257'd1);
    check("t1_addr_T1", 257'(a_mem_addr), 257'h80);
    @(negedge clk);
    check("t1_valid_T2", 257'(a_if.rd_rsp_valid), 257'd0);
    check("t1_credit", 257'(a_cnt), 257'd15);
    @(negedge clk);
    check("t1_valid_T3", 257'(a_if.rd_rsp_valid), 257'd1);
    check("t1_pd_T3", a_if.rd_rsp_pd, {1'b1, {32{8'hA5}}});
    tick();
    a_if.rd_rsp_ready = 1'b1;
    drain();
    pop_a(1);
    check("t1_credit_back", 257'(a_cnt), 257'd16);

    // Backpressured burst
    send(1'b0, 64'h2000, 15'd3);
    tick(3);
    a_if.rd_rsp_ready = 1'b0;
    tick(5);
    a_if.rd_rsp_ready = 1'b1;
    drain();
    check("t2_credit", 257'(a_cnt), 257'd12);
    pop_a(4);
    check("t2_credit_back", 257'(a_cnt), 257'd16);

    // Credit exhaustion on LAT_DEPTH=2
    b_if.rd_rsp_ready = 1'b1;
    send(1'b1, 64'h0, 15'd4);
    tick(20);
    check("t3_issues_2", 257'(b_issued), 257'd2);
    check("t3_credit_0", 257'(b_cnt), 257'd0);
    b_if.rd_cdt_lat_fifo_pop = 1'b1;
    tick();
    b_if.rd_cdt_lat_fifo_pop = 1'b0;
    tick(20);
    check("t3_issues_3", 257'(b_issued), 257'd3);
    check("t3_credit_0b", 257'(b_cnt), 257'd0);

    // Issue and credit return in the same cycle
    send(1'b0, 64'h4000, 15'd15);
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      hit = a_mem_en && (a_cnt == 8'd5);
    end
    check("t4_reach_5", 257'(hit), 257'd1);
    a_if.rd_cdt_lat_fifo_pop = 1'b1;
    @(posedge clk);
    #1;
    a_if.rd_cdt_lat_fifo_pop = 1'b0;
    check("t4_credit_hold", 257'(a_cnt), 257'd5);
    drain();
    check("t4_credit_end", 257'(a_cnt), 257'd1);
    pop_a(15);
    check("t4_credit_back", 257'(a_cnt), 257'd16);

    // Surplus credit return
    pop_a(1);
    check("t6_err_set", 257'(a_err), 257'd1);
    check("t6_credit_max", 257'(a_cnt), 257'd16);
    tick(5);
    check("t6_err_sticky", 257'(a_err), 257'd1);

    // Reset in the middle of a burst
    b0 = beats;
    send(1'b0, 64'h8000, 15'd7);
    for (int t = 0; t < 100 && (beats - b0) < 3; t++) tick();
    check("t5_three_beats", 257'((beats - b0) >= 3), 257'd1);
    rst = 1'b1;
    exp_pd.delete();
    exp_addr.delete();
    tick();
    rst = 1'b0;
    check("t5_valid_0", 257'(a_if.rd_rsp_valid), 257'd0);
    check("t5_credit", 257'(a_cnt), 257'd16);
    check("t5_err_clr", 257'(a_err), 257'd0);
    check("t5_mem_en", 257'(a_mem_en), 257'd0);
    hit = 1'b0;
    for (int t = 0; t < 3 && !hit; t++) begin
      @(negedge clk);
      hit = a_if.rd_req_ready;
    end
    check("t5_ready", 257'(hit), 257'd1);
    tick();
    send(1'b0, 64'h40, 15'd0);
    drain();
    check("t5_credit_after", 257'(a_cnt), 257'd15);
    check("t5_valid_idle", 257'(a_if.rd_rsp_valid), 257'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
